// File: rtl/counter_chain_ctrl_pkg.sv
// counter_chain_ctrl_pkg: state encoding, default moduli and width helpers for the counter chain
package counter_chain_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    localparam int DEF_DIV_LO = 50;
    localparam int DEF_DIV_HI = 10;
    localparam int DEF_TGT_W = 8;
    localparam int DEF_LO_W = $clog2(DEF_DIV_LO);
    localparam int DEF_HI_W = $clog2(DEF_DIV_HI);
endpackage

// File: rtl/counter_chain_ctrl_if.sv
// counter_chain_ctrl_if: command and status bundle between the controller and its user
interface counter_chain_ctrl_if
    import counter_chain_ctrl_pkg::*;
#(
    parameter int DIV_LO = DEF_DIV_LO,
    parameter int DIV_HI = DEF_DIV_HI,
    parameter int TGT_W = DEF_TGT_W
);
    localparam int LO_W = $clog2(DIV_LO);
    localparam int HI_W = $clog2(DIV_HI);
    logic start, stop, clear, periodic;
    logic [TGT_W-1:0] target;
    logic [LO_W-1:0] count_lo;
    logic [HI_W-1:0] count_hi;
    logic [TGT_W-1:0] epoch;
    logic tick_lo, tick_hi, done, busy;
    state_t state;
    modport master (
        output start, stop, clear, periodic, target,
        input count_lo, count_hi, epoch, tick_lo, tick_hi, done, busy, state
    );
    modport slave (
        input start, stop, clear, periodic, target,
        output count_lo, count_hi, epoch, tick_lo, tick_hi, done, busy, state
    );
endinterface

// File: rtl/counter_chain_prescaler.sv
// counter_chain_prescaler: two-stage clock-enable divider; clr wins over en
module counter_chain_prescaler
    import counter_chain_ctrl_pkg::*;
#(
    parameter int DIV_LO = DEF_DIV_LO,
    parameter int DIV_HI = DEF_DIV_HI,
    localparam int LO_W = $clog2(DIV_LO),
    localparam int HI_W = $clog2(DIV_HI)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [LO_W-1:0] count_lo,
    output logic [HI_W-1:0] count_hi,
    output logic            tick_lo,
    output logic            tick_hi
);
    assign tick_lo = en && count_lo == LO_W'(DIV_LO - 1);
    assign tick_hi = tick_lo && count_hi == HI_W'(DIV_HI - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_lo <= '0;
            count_hi <= '0;
        end else if (en) begin
            count_lo <= tick_lo ? '0 : count_lo + 1'b1;
            if (tick_lo) count_hi <= tick_hi ? '0 : count_hi + 1'b1;
        end
    end
endmodule

// File: rtl/counter_chain_ctrl.sv
// counter_chain_ctrl: run/pause/clear sequencing and epoch completion over the divider chain
module counter_chain_ctrl
    import counter_chain_ctrl_pkg::*;
#(
    parameter int DIV_LO = DEF_DIV_LO,
    parameter int DIV_HI = DEF_DIV_HI,
    parameter int TGT_W = DEF_TGT_W
) (
    input logic clk,
    input logic rst,
    counter_chain_ctrl_if.slave bus
);
    state_t state_q, state_d;
    logic [TGT_W-1:0] target_q, epoch_q;
    logic periodic_q, done_q, accept, final_tick, tick_hi;

    assign accept = !bus.clear && bus.start && !bus.stop && bus.target != '0 &&
                    (state_q == IDLE || state_q == DONE);
    assign final_tick = tick_hi && epoch_q == target_q - 1'b1;

    counter_chain_prescaler #(.DIV_LO(DIV_LO), .DIV_HI(DIV_HI)) u_prescaler (
        .clk(clk),
        .rst(rst),
        .clr(bus.clear || accept),
        .en(state_q == RUN),
        .count_lo(bus.count_lo),
        .count_hi(bus.count_hi),
        .tick_lo(bus.tick_lo),
        .tick_hi(tick_hi)
    );

    // completion beats a coincident stop
    always_comb begin
        state_d = bus.clear ? IDLE :
                  accept ? RUN :
                  (state_q == RUN) ? (final_tick ? (periodic_q ? RUN : DONE) : bus.stop ? PAUSE : RUN) :
                  (state_q == PAUSE && bus.start && !bus.stop) ? RUN : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            target_q <= '0;
            periodic_q <= 1'b0;
            epoch_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q <= final_tick && !bus.clear;
            if (accept) begin
                target_q <= bus.target;
                periodic_q <= bus.periodic;
            end
            epoch_q <= (bus.clear || accept) ? '0 :
                       final_tick ? (periodic_q ? '0 : target_q) :
                       tick_hi ? epoch_q + 1'b1 : epoch_q;
        end
    end

    assign bus.tick_hi = tick_hi;
    assign bus.epoch = epoch_q;
    assign bus.done = done_q;
    assign bus.busy = state_q == RUN || state_q == PAUSE;
    assign bus.state = state_q;
endmodule
